axis_bram_adapter_v1_0_bram_writer: RTL and testbench

Downstream consumer of the AXIS slave front end in the AXIS-to-BRAM adapter. It takes the front end's post-handshake word stream (data, valid, accept) and writes each word into a BRAM port at consecutive byte addresses from a programmed base. It throttles the front end through the accept signal so that exactly the programmed number of words is written, then signals completion. It sits between the AXIS slave front end and the BRAM controller port.

---
 rtl/axis_bram_adapter_v1_0_bram_writer.sv | 168 ++++++++++++++++
 tb/tb_axis_bram_adapter_v1_0_bram_writer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_bram_adapter_v1_0_bram_writer.sv
// Stream-to-BRAM writer: stores a programmed number of upstream words at
// consecutive byte addresses from a base and throttles the front end via DIN_ACCEP.
module axis_bram_adapter_v1_0_bram_writer #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int C_BRAM_ADDR_WIDTH    = 32,
    parameter int C_COUNT_WIDTH        = 16
) (
    input  logic                              S_AXIS_ACLK,
    input  logic                              S_AXIS_ARESETN,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   DIN,
    input  logic                              DIN_VALID,
    output logic                              DIN_ACCEP,
    input  logic                              START,
    input  logic [C_BRAM_ADDR_WIDTH-1:0]      BASE_ADDR,
    input  logic [C_COUNT_WIDTH-1:0]          WORD_COUNT,
    output logic                              BUSY,
    output logic                              DONE,
    output logic [C_COUNT_WIDTH-1:0]          WORDS_WRITTEN,
    output logic                              OVERRUN,
    output logic                              BRAM_EN,
    output logic [C_S_AXIS_TDATA_WIDTH/8-1:0] BRAM_WE,
    output logic [C_BRAM_ADDR_WIDTH-1:0]      BRAM_ADDR,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   BRAM_DIN
);

    localparam int BYTES = C_S_AXIS_TDATA_WIDTH / 8;
    localparam int CW1   = C_COUNT_WIDTH + 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    state_t                            r_state;
    state_t                            w_state_next;
    logic [C_BRAM_ADDR_WIDTH-1:0]      r_base;
    logic [C_COUNT_WIDTH-1:0]          r_count;
    logic [C_COUNT_WIDTH-1:0]          r_words_written;
    logic                              r_pending;
    logic                              r_overrun;
    logic                              r_done;
    logic                              r_bram_en;
    logic [C_BRAM_ADDR_WIDTH-1:0]      r_bram_addr;
    logic [C_S_AXIS_TDATA_WIDTH-1:0]   r_bram_din;

    logic                              w_start_job;
    logic                              w_start_zero;
    logic                              w_capture;
    logic                              w_last;
    logic                              w_stray;
    logic                              w_din_accep;
    logic [C_COUNT_WIDTH-1:0]          w_ww_inc;
    logic [CW1-1:0]                    w_in_flight;
    logic [C_BRAM_ADDR_WIDTH-1:0]      w_addr;

    // Acceptance budget: words written plus the one possibly in flight
    always_comb begin
        w_in_flight = {1'b0, r_words_written} + {{C_COUNT_WIDTH{1'b0}}, r_pending};
        w_din_accep = (r_state == ST_WRITE) && (w_in_flight < {1'b0, r_count});
    end

    // Progress increment and target address, both modulo their widths
    always_comb begin
        w_ww_inc = r_words_written + {{(C_COUNT_WIDTH-1){1'b0}}, 1'b1};
        w_addr   = r_base + (C_BRAM_ADDR_WIDTH'(r_words_written) * C_BRAM_ADDR_WIDTH'(BYTES));
    end

    // Next-state and per-cycle control decode
    always_comb begin
        w_state_next = r_state;
        w_start_job  = 1'b0;
        w_start_zero = 1'b0;
        w_capture    = 1'b0;
        w_last       = 1'b0;
        w_stray      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_stray = DIN_VALID;
                if (START) begin
                    if (WORD_COUNT != {C_COUNT_WIDTH{1'b0}}) begin
                        w_start_job  = 1'b1;
                        w_state_next = ST_WRITE;
                    end else begin
                        w_start_zero = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WRITE: begin
                w_capture = DIN_VALID;
                w_last    = DIN_VALID && (w_ww_inc == r_count);
                if (w_last) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_WRITE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge S_AXIS_ACLK) begin
        if (!S_AXIS_ARESETN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Job parameters, progress, completion pulse and BRAM write port
    always_ff @(posedge S_AXIS_ACLK) begin
        if (!S_AXIS_ARESETN) begin
            r_base          <= {C_BRAM_ADDR_WIDTH{1'b0}};
            r_count         <= {C_COUNT_WIDTH{1'b0}};
            r_words_written <= {C_COUNT_WIDTH{1'b0}};
            r_pending       <= 1'b0;
            r_done          <= 1'b0;
            r_bram_en       <= 1'b0;
            r_bram_addr     <= {C_BRAM_ADDR_WIDTH{1'b0}};
            r_bram_din      <= {C_S_AXIS_TDATA_WIDTH{1'b0}};
        end else begin
            r_pending <= w_din_accep;
            r_done    <= 1'b0;
            r_bram_en <= 1'b0;
            if (w_start_job) begin
                r_base          <= BASE_ADDR;
                r_count         <= WORD_COUNT;
                r_words_written <= {C_COUNT_WIDTH{1'b0}};
            end else if (w_start_zero) begin
                r_words_written <= {C_COUNT_WIDTH{1'b0}};
                r_done          <= 1'b1;
            end else if (w_capture) begin
                r_bram_en       <= 1'b1;
                r_bram_addr     <= w_addr;
                r_bram_din      <= DIN;
                r_words_written <= w_ww_inc;
                r_done          <= w_last;
            end
        end
    end

    // Sticky overrun; a stray word in the START cycle still counts as stray
    always_ff @(posedge S_AXIS_ACLK) begin
        if (!S_AXIS_ARESETN) begin
            r_overrun <= 1'b0;
        end else if (w_stray) begin
            r_overrun <= 1'b1;
        end else if (w_start_job || w_start_zero) begin
            r_overrun <= 1'b0;
        end
    end

    assign DIN_ACCEP     = w_din_accep;
    assign BUSY          = (r_state == ST_WRITE);
    assign DONE          = r_done;
    assign WORDS_WRITTEN = r_words_written;
    assign OVERRUN       = r_overrun;
    assign BRAM_EN       = r_bram_en;
    assign BRAM_WE       = {BYTES{r_bram_en}};
    assign BRAM_ADDR     = r_bram_addr;
    assign BRAM_DIN      = r_bram_din;

endmodule

// File: tb/tb_axis_bram_adapter_v1_0_bram_writer.sv
// Directed bench for the BRAM writer: a small front-end model feeds words and
// every BRAM strobe, DONE pulse and DIN_ACCEP value is recorded per cycle.
module tb_axis_bram_adapter_v1_0_bram_writer;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [31:0] din;
    logic        din_valid;
    logic        din_accep;
    logic        start;
    logic [11:0] base_addr;
    logic [15:0] word_count;
    logic        busy;
    logic        done;
    logic [15:0] words_written;
    logic        overrun;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [11:0] bram_addr;
    logic [31:0] bram_din;

    always #5 clk = ~clk;

    axis_bram_adapter_v1_0_bram_writer #(
        .C_S_AXIS_TDATA_WIDTH(32),
        .C_BRAM_ADDR_WIDTH   (12),
        .C_COUNT_WIDTH       (16)
    ) dut (
        .S_AXIS_ACLK   (clk),
        .S_AXIS_ARESETN(aresetn),
        .DIN           (din),
        .DIN_VALID     (din_valid),
        .DIN_ACCEP     (din_accep),
        .START         (start),
        .BASE_ADDR     (base_addr),
        .WORD_COUNT    (word_count),
        .BUSY          (busy),
        .DONE          (done),
        .WORDS_WRITTEN (words_written),
        .OVERRUN       (overrun),
        .BRAM_EN       (bram_en),
        .BRAM_WE       (bram_we),
        .BRAM_ADDR     (bram_addr),
        .BRAM_DIN      (bram_din)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // per-run records
    int          cyc;
    int          n_st;
    logic [11:0] st_addr [16];
    logic [31:0] st_data [16];
    logic        st_done [16];
    logic        st_busy [16];
    logic [15:0] st_ww   [16];
    logic [3:0]  st_we   [16];
    int          st_cyc  [16];
    int          n_done;
    int          done_cyc;
    logic        accep_tr [64];
    logic        busy_tr  [64];
    logic        en_tr    [64];
    logic [3:0]  we_tr    [64];
    logic [11:0] addr_tr  [64];

    // front-end model
    logic [63:0] offer_mask;
    int          src_words;
    int          src_sent;
    logic [31:0] src_val0;
    logic        hs_pend;
    logic [31:0] hs_word;
    int          n_hs;

    // snapshot of all outputs at one chosen cycle
    int          snap_k;
    logic        sn_accep, sn_busy, sn_done, sn_ovr, sn_en;
    logic [15:0] sn_ww;
    logic [3:0]  sn_we;
    logic [11:0] sn_addr;
    logic [31:0] sn_din;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: sample outputs at the falling edge, then drive the front end.
    task automatic tick();
        @(negedge clk);
        if (cyc < 64) begin
            accep_tr[cyc] = din_accep;
            busy_tr[cyc]  = busy;
            en_tr[cyc]    = bram_en;
            we_tr[cyc]    = bram_we;
            addr_tr[cyc]  = bram_addr;
        end
        if (bram_en) begin
            if (n_st < 16) begin
                st_addr[n_st] = bram_addr;
                st_data[n_st] = bram_din;
                st_done[n_st] = done;
                st_busy[n_st] = busy;
                st_ww[n_st]   = words_written;
                st_we[n_st]   = bram_we;
                st_cyc[n_st]  = cyc;
            end
            n_st++;
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (cyc == snap_k) begin
            sn_accep = din_accep; sn_busy = busy; sn_done = done; sn_ovr = overrun;
            sn_en = bram_en; sn_ww = words_written; sn_we = bram_we;
            sn_addr = bram_addr; sn_din = bram_din;
        end
        din_valid = hs_pend;
        din       = hs_word;
        hs_pend   = 1'b0;
        if (cyc < 64 && offer_mask[cyc] && src_sent < src_words && din_accep) begin
            hs_pend = 1'b1;
            hs_word = src_val0 + 32'(src_sent);
            src_sent++;
            n_hs++;
        end
        cyc++;
    endtask

    task automatic clear_rec();
        n_st = 0; n_done = 0; done_cyc = -1; n_hs = 0; cyc = 0;
        src_sent = 0; hs_pend = 1'b0; hs_word = 32'h0;
    endtask

    // START at cycle 0; optional extra START (base 0x700, count 1) and reset cycle.
    task automatic run(input logic [11:0] b, input logic [15:0] c, input logic [63:0] mask,
                       input int nwords, input logic [31:0] v0, input int ncyc,
                       input int mid_k, input int rst_k, input int snap);
        clear_rec();
        offer_mask = mask; src_words = nwords; src_val0 = v0; snap_k = snap;
        for (int k = 0; k < ncyc; k++) begin
            tick();
            start      = (k == 0) || (k == mid_k);
            base_addr  = (k == mid_k) ? 12'h700 : b;
            word_count = (k == mid_k) ? 16'd1 : c;
            aresetn    = (k != rst_k);
            if (k == rst_k) hs_pend = 1'b0;
        end
        start = 1'b0;
        aresetn = 1'b1;
    endtask

    initial begin
        int low_cnt;
        int busy_cnt;
        aresetn = 1'b0; start = 1'b0; din_valid = 1'b0; din = 32'h0;
        base_addr = 12'h0; word_count = 16'd0;
        offer_mask = 64'h0; src_words = 0; src_val0 = 32'h0; snap_k = -1;
        clear_rec();
        repeat (3) tick();
        aresetn = 1'b1;

        // reset state
        check_val("rst_accep", din_accep, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_ww", words_written, 16'd0);
        check_val("rst_ovr", overrun, 1'b0);
        check_val("rst_en", bram_en, 1'b0);
        check_val("rst_we", bram_we, 4'h0);
        check_val("rst_addr", bram_addr, 12'h0);
        check_val("rst_din", bram_din, 32'h0);

        // burst: base 0x100, count 4, words back-to-back
        run(12'h100, 16'd4, {64{1'b1}}, 4, 32'hA0, 12, -1, -1, -1);
        check_val("burst_nstrobe", n_st, 4);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("burst_addr%0d", i), st_addr[i], 12'h100 + 12'(4 * i));
            check_val($sformatf("burst_data%0d", i), st_data[i], 32'hA0 + 32'(i));
        end
        check_val("burst_busy_t1", busy_tr[1], 1'b1);
        check_val("burst_accep_t1", accep_tr[1], 1'b1);
        check_val("burst_first_cyc", st_cyc[0], 3);
        check_val("burst_we", st_we[0], 4'hF);
        check_val("burst_ndone", n_done, 1);
        check_val("burst_done_cyc", done_cyc, 6);
        check_val("burst_done_3rd", st_done[2], 1'b0);
        check_val("burst_done_4th", st_done[3], 1'b1);
        check_val("burst_busy_last", st_busy[3], 1'b0);
        check_val("burst_ww_last", st_ww[3], 16'd4);
        check_val("burst_accep_after", accep_tr[7], 1'b0);
        check_val("burst_en_after", en_tr[7], 1'b0);
        check_val("burst_we_after", we_tr[7], 4'h0);
        check_val("burst_addr_hold", addr_tr[7], 12'h10C);

        // gapped upstream: offers on cycles 1, 4, 7
        run(12'h200, 16'd3, 64'h92, 3, 32'hB0, 14, -1, -1, -1);
        check_val("gap_nstrobe", n_st, 3);
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("gap_addr%0d", i), st_addr[i], 12'h200 + 12'(4 * i));
            check_val($sformatf("gap_data%0d", i), st_data[i], 32'hB0 + 32'(i));
        end
        check_val("gap_done_2nd", st_done[1], 1'b0);
        check_val("gap_ndone", n_done, 1);
        check_val("gap_done_cyc", done_cyc, 9);
        check_val("gap_bubble", accep_tr[6], 1'b0);
        low_cnt = 0;
        for (int i = 1; i <= 7; i++) low_cnt += (accep_tr[i] ? 0 : 1);
        check_val("gap_bubble_cnt", low_cnt, 1);

        // over-supply: count 2, five words offered
        run(12'h040, 16'd2, {64{1'b1}}, 5, 32'hC0, 16, -1, -1, -1);
        check_val("over_nstrobe", n_st, 2);
        check_val("over_nhs", n_hs, 2);
        check_val("over_addr1", st_addr[1], 12'h044);
        check_val("over_done_cyc", done_cyc, 4);
        check_val("over_accep5", accep_tr[5], 1'b0);
        check_val("over_accep10", accep_tr[10], 1'b0);
        check_val("over_ovr", overrun, 1'b0);

        // count zero
        run(12'h500, 16'd0, 64'h0, 0, 32'h0, 6, -1, -1, 1);
        check_val("zero_ndone", n_done, 1);
        check_val("zero_done_cyc", done_cyc, 1);
        check_val("zero_nstrobe", n_st, 0);
        check_val("zero_ww", sn_ww, 16'd0);
        busy_cnt = 0;
        for (int i = 0; i < 6; i++) busy_cnt += (busy_tr[i] ? 1 : 0);
        check_val("zero_busy", busy_cnt, 0);

        // START mid-job must not disturb base, count or progress
        run(12'h300, 16'd4, {64{1'b1}}, 4, 32'hD0, 12, 3, -1, -1);
        check_val("mid_nstrobe", n_st, 4);
        check_val("mid_addr0", st_addr[0], 12'h300);
        check_val("mid_addr3", st_addr[3], 12'h30C);
        check_val("mid_ww_last", st_ww[3], 16'd4);
        check_val("mid_ndone", n_done, 1);
        check_val("mid_done_cyc", done_cyc, 6);

        // address wrap at the top of a 12-bit space
        run(12'hFF8, 16'd4, {64{1'b1}}, 4, 32'hE0, 12, -1, -1, -1);
        check_val("wrap_nstrobe", n_st, 4);
        check_val("wrap_addr0", st_addr[0], 12'hFF8);
        check_val("wrap_addr1", st_addr[1], 12'hFFC);
        check_val("wrap_addr2", st_addr[2], 12'h000);
        check_val("wrap_addr3", st_addr[3], 12'h004);
        check_val("wrap_done_cyc", done_cyc, 6);

        // reset after two of six words
        run(12'h080, 16'd6, {64{1'b1}}, 6, 32'hF0, 14, -1, 4, 5);
        check_val("rjob_nstrobe", n_st, 2);
        check_val("rjob_addr1", st_addr[1], 12'h084);
        check_val("rjob_ndone", n_done, 0);
        check_val("rjob_accep", sn_accep, 1'b0);
        check_val("rjob_busy", sn_busy, 1'b0);
        check_val("rjob_done", sn_done, 1'b0);
        check_val("rjob_ww", sn_ww, 16'd0);
        check_val("rjob_ovr", sn_ovr, 1'b0);
        check_val("rjob_en", sn_en, 1'b0);
        check_val("rjob_we", sn_we, 4'h0);
        check_val("rjob_addr", sn_addr, 12'h0);
        check_val("rjob_din", sn_din, 32'h0);

        // stray word while idle
        clear_rec();
        offer_mask = 64'h0; src_words = 0; snap_k = -1;
        tick();
        din_valid = 1'b1;
        din = 32'hDEAD_BEEF;
        tick();
        check_val("stray_ovr", overrun, 1'b1);
        tick();
        tick();
        check_val("stray_ovr_hold", overrun, 1'b1);
        check_val("stray_nstrobe", n_st, 0);

        // next START clears it
        run(12'h010, 16'd1, {64{1'b1}}, 1, 32'h55, 8, -1, -1, 1);
        check_val("clr_ovr", sn_ovr, 1'b0);
        check_val("clr_nstrobe", n_st, 1);
        check_val("clr_addr", st_addr[0], 12'h010);
        check_val("clr_data", st_data[0], 32'h55);
        check_val("clr_done_cyc", done_cyc, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
